// File: rtl/cfu_ram_arbiter.sv
// Round-robin arbiter sharing the CFU's read-only Wishbone master port among NUM_REQ fetch requesters.
// Optional bus-cycle watchdog enabled by defining CFU_RAM_ARB_TIMEOUT_EN.
module cfu_ram_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*30-1:0] req_adr,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [29:0]           cfu_ram_adr,
  output logic [31:0]           cfu_ram_dat_mosi,
  output logic [3:0]            cfu_ram_sel,
  output logic                  cfu_ram_cyc,
  output logic                  cfu_ram_stb,
  output logic                  cfu_ram_we,
  output logic [2:0]            cfu_ram_cti,
  output logic [1:0]            cfu_ram_bte,
  input  logic [31:0]           cfu_ram_dat_miso,
  input  logic                  cfu_ram_ack,
  input  logic                  cfu_ram_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("cfu_ram_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, gnt_q, win_idx;
  logic             win_found;
  logic [IDX_W:0]   pos;
  logic [29:0]      adr_arr [NUM_REQ];
  logic             timeout_hit;

  // Read-only classic Wishbone master: the write-side signals never change.
  assign cfu_ram_dat_mosi = 32'h0;
  assign cfu_ram_sel      = 4'b1111;
  assign cfu_ram_we       = 1'b0;
  assign cfu_ram_cti      = 3'b000;
  assign cfu_ram_bte      = 2'b00;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) adr_arr[i] = req_adr[30*i +: 30];
  end

  // Scan from ptr_q downwards in priority so the highest-priority requester is assigned last.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    win_idx   = '0;
    win_found = 1'b0;
    pos       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
      if (req_valid[pos[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[IDX_W-1:0];
      end
    end
  end

`ifdef CFU_RAM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  // Counter is held at zero outside BUS, so it starts from zero on every bus cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 to_cnt_q <= '0;
    else if (state_q != S_BUS)  to_cnt_q <= '0;
    else                        to_cnt_q <= to_cnt_q + 16'd1;
  end

  assign timeout_hit = (state_q == S_BUS) && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rsp_valid   = '0;
    busy        = (state_q != S_IDLE);
    cfu_ram_cyc = (state_q == S_BUS);
    cfu_ram_stb = (state_q == S_BUS);
    case (state_q)
      S_IDLE: if (win_found) state_d = S_BUS;
      S_BUS:  if (cfu_ram_ack || cfu_ram_err || timeout_hit) state_d = S_RESP;
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      cfu_ram_adr <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            gnt_q       <= win_idx;
            cfu_ram_adr <= adr_arr[win_idx];
          end
        end
        S_BUS: begin
          // err outranks ack; a bus termination outranks the watchdog.
          if (cfu_ram_err) begin
            rsp_err <= 1'b1;
          end else if (cfu_ram_ack) begin
            rsp_data <= cfu_ram_dat_miso;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        S_RESP: begin
          ptr_q <= (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_ram_arbiter.sv
// Scoreboard bench for cfu_ram_arbiter: directed requests, a programmable Wishbone slave and a response monitor.
module tb_cfu_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [59:0] req_adr;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [29:0] cfu_ram_adr;
  logic [31:0] cfu_ram_dat_mosi;
  logic [3:0]  cfu_ram_sel;
  logic        cfu_ram_cyc;
  logic        cfu_ram_stb;
  logic        cfu_ram_we;
  logic [2:0]  cfu_ram_cti;
  logic [1:0]  cfu_ram_bte;
  logic [31:0] cfu_ram_dat_miso;
  logic        cfu_ram_ack = 1'b0;
  logic        cfu_ram_err = 1'b0;

  cfu_ram_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_adr          (req_adr),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .busy             (busy),
    .cfu_ram_adr      (cfu_ram_adr),
    .cfu_ram_dat_mosi (cfu_ram_dat_mosi),
    .cfu_ram_sel      (cfu_ram_sel),
    .cfu_ram_cyc      (cfu_ram_cyc),
    .cfu_ram_stb      (cfu_ram_stb),
    .cfu_ram_we       (cfu_ram_we),
    .cfu_ram_cti      (cfu_ram_cti),
    .cfu_ram_bte      (cfu_ram_bte),
    .cfu_ram_dat_miso (cfu_ram_dat_miso),
    .cfu_ram_ack      (cfu_ram_ack),
    .cfu_ram_err      (cfu_ram_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [29:0] adr;
    logic [31:0] data;
    logic        err;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [29:0] adr, input logic [31:0] data,
                      input logic err, input int len);
    exp_t e;
    e.idx = idx; e.adr = adr; e.data = data; e.err = err; e.len = len;
    exp_q.push_back(e);
  endtask

  // Slave: data is a function of the address; ack (optionally with err) after slv_wait wait states.
  int          slv_wait   = 0;
  logic        slv_err    = 1'b0;
  logic        slv_never  = 1'b0;
  logic [31:0] slv_salt   = 32'h0;
  int          cyc_len    = 0;
  logic [29:0] seen_adr   = '0;
  logic        in_cyc     = 1'b0;

  assign cfu_ram_dat_miso = {cfu_ram_adr, 2'b00} ^ slv_salt;

  always @(negedge clk) begin
    if (cfu_ram_cyc && cfu_ram_stb) begin
      if (!in_cyc) begin
        in_cyc  = 1'b1;
        cyc_len = 0;
      end
      seen_adr = cfu_ram_adr;
      if (!slv_never && cyc_len == slv_wait) begin
        cfu_ram_ack = 1'b1;
        cfu_ram_err = slv_err;
      end else begin
        cfu_ram_ack = 1'b0;
        cfu_ram_err = 1'b0;
      end
      cyc_len++;
    end else begin
      in_cyc      = 1'b0;
      cfu_ram_ack = 1'b0;
      cfu_ram_err = 1'b0;
    end
  end

  // Monitor: every completion pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] onehot;
    if (reset && rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_valid", rsp_valid, 2'b00);
      end else begin
        e      = exp_q.pop_front();
        onehot = 2'(1 << e.idx);
        check("rsp_valid_grant", rsp_valid, onehot);
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", rsp_err, e.err);
        check("bus_adr", seen_adr, e.adr);
        check("cyc_length", cyc_len, e.len);
      end
    end
  end

  task automatic wait_rsp(input int n, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != 2'b00) seen++;
    end
    if (seen < n) check("wait_rsp_timeout", seen, n);
  endtask

  task automatic wait_cyc(input int budget);
    int cyc = 0;
    while (!cfu_ram_cyc && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!cfu_ram_cyc) check("wait_cyc_timeout", cfu_ram_cyc, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    req_adr   = '0;
    repeat (2) @(negedge clk);
    check("reset_cyc_stb", {cfu_ram_cyc, cfu_ram_stb}, 2'b00);
    check("reset_rsp_valid_busy", {rsp_valid, busy}, 3'b000);
    check("reset_rsp", {rsp_err, rsp_data}, 33'h0);
    check("reset_adr", cfu_ram_adr, 30'h0);
    check("const_outputs", {cfu_ram_we, cfu_ram_sel, cfu_ram_cti, cfu_ram_bte, cfu_ram_dat_mosi},
          {1'b0, 4'b1111, 3'b000, 2'b00, 32'h0});
    reset = 1'b1;

    // Contention from ptr 0: grants alternate 0,1,0,1.
    @(negedge clk);
    slv_wait = 0;
    slv_salt = 32'h1234_0000;
    req_adr  = {30'h20, 30'h10};
    push(0, 30'h10, 32'h1234_0040, 1'b0, 1);
    push(1, 30'h20, 32'h1234_0080, 1'b0, 1);
    push(0, 30'h10, 32'h1234_0040, 1'b0, 1);
    push(1, 30'h20, 32'h1234_0080, 1'b0, 1);
    req_valid = 2'b11;
    wait_rsp(4, 40);
    req_valid = 2'b00;

    // Single request, zero-wait slave: rsp_valid two edges after the request is seen.
    repeat (2) @(negedge clk);
    slv_salt = 32'hDEAD_BAEF;
    req_adr  = {30'h0, 30'h100};
    push(0, 30'h100, 32'hDEAD_BEEF, 1'b0, 1);
    req_valid = 2'b01;
    @(posedge clk);
    @(posedge clk);
    #1 check("single_latency", rsp_valid, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;

    // ack+err together on the third BUS cycle: error, data unchanged.
    repeat (2) @(negedge clk);
    slv_wait = 2;
    slv_err  = 1'b1;
    slv_salt = 32'hFFFF_FFFF;
    req_adr  = {30'h3ABC, 30'h0};
    push(1, 30'h3ABC, 32'hDEAD_BEEF, 1'b1, 3);
    req_valid = 2'b10;
    wait_rsp(1, 40);
    req_valid = 2'b00;
    slv_err   = 1'b0;

    // Requester 0 drops mid-BUS against a 5-wait-state slave; requester 1 follows.
    repeat (2) @(negedge clk);
    slv_wait = 5;
    slv_salt = 32'h0BAD_0000;
    req_adr  = {30'h66, 30'h55};
    push(0, 30'h55, 32'h0BAD_0154, 1'b0, 6);
    push(1, 30'h66, 32'h0BAD_0198, 1'b0, 6);
    req_valid = 2'b11;
    wait_cyc(20);
    repeat (2) @(negedge clk);
    req_valid[0] = 1'b0;
    wait_rsp(2, 60);
    req_valid = 2'b00;

    // Reset asserted mid-BUS, then requester 1 alone is granted right after release.
    repeat (2) @(negedge clk);
    slv_never = 1'b1;
    req_adr   = {30'h77, 30'h0};
    req_valid = 2'b10;
    wait_cyc(20);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset_cyc_stb", {cfu_ram_cyc, cfu_ram_stb}, 2'b00);
    check("async_reset_rsp_valid_busy", {rsp_valid, busy}, 3'b000);
    check("async_reset_rsp_data", rsp_data, 32'h0);
    slv_never = 1'b0;
    slv_wait  = 0;
    slv_salt  = 32'h0;
    push(1, 30'h77, 32'h0000_01DC, 1'b0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("post_reset_grant_cyc", cfu_ram_cyc, 1'b1);
    check("post_reset_grant_adr", cfu_ram_adr, 30'h77);
    wait_rsp(1, 20);
    req_valid = 2'b00;

    // Slave never acknowledges.
    repeat (2) @(negedge clk);
    slv_never = 1'b1;
    req_adr   = {30'h0, 30'h99};
`ifdef CFU_RAM_ARB_TIMEOUT_EN
    push(0, 30'h99, 32'h0, 1'b1, 8);
    req_valid = 2'b01;
    wait_rsp(1, 40);
    req_valid = 2'b00;
    slv_never = 1'b0;
`else
    begin
      int held = 0;
      req_valid = 2'b01;
      wait_cyc(10);
      for (int i = 0; i < 110; i++) begin
        @(negedge clk);
        if (cfu_ram_cyc && cfu_ram_stb) held++;
      end
      check("no_timeout_cyc_held", held, 110);
      reset     = 1'b0;
      req_valid = 2'b00;
      @(negedge clk);
      reset     = 1'b1;
      slv_never = 1'b0;
    end
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cfu_ram_arbiter.md
# cfu_ram_arbiter

Round-robin arbiter that shares the CFU's single read-only Wishbone master port (cfu_ram_*) between NUM_REQ internal fetch requesters (e.g. matrix-value and filter-value fetch engines). Each requester posts a word address and receives one data word or an error. The arbiter owns the bus-cycle state machine, so requesters never drive cyc/stb themselves. It sits between the CFU command FSM / fetch engines and the SoC-side cfu_ram bus.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 255, bus-cycle watchdog limit in cycles (used only with CFU_RAM_ARB_TIMEOUT_EN)
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester read request; held high until that requester's rsp_valid
- req_adr  in  NUM_REQ*30  word addresses; slice i = [30*i+29:30*i]; stable while req_valid[i]
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rsp_data  out  32  read data, valid with any rsp_valid bit
- rsp_err  out  1  error flag, valid with any rsp_valid bit
- busy  out  1  high while not IDLE
- cfu_ram_adr  out  30  word address
- cfu_ram_dat_mosi  out  32  constant 0
- cfu_ram_sel  out  4  constant 4'b1111
- cfu_ram_cyc / cfu_ram_stb  out  1 each  asserted together for a bus cycle
- cfu_ram_we  out  1  constant 0
- cfu_ram_cti  out  3  constant 0 (classic)
- cfu_ram_bte  out  2  constant 0
- cfu_ram_dat_miso  in  32  read data
- cfu_ram_ack / cfu_ram_err  in  1 each  cycle termination

## Operation
- States: IDLE, BUS, RESP.
- IDLE: if any req_valid, pick winner by round-robin starting at ptr; latch gnt index and req_adr slice into cfu_ram_adr; go BUS with cyc/stb=1 from next edge.
- BUS: cyc/stb held high, adr stable. On err: rsp_err<=1, go RESP. On ack (no err): rsp_data<=dat_miso, rsp_err<=0, go RESP. ack and err same cycle -> err wins, data not latched. cyc/stb drop on the same edge.
- RESP: rsp_valid[gnt]=1 for exactly this cycle; ptr<=(gnt+1) mod NUM_REQ; go IDLE.
- ptr after reset = 0; requester ptr has highest priority, then ascending with wrap.
- req_valid[gnt] dropping during BUS: bus cycle still completes (Wishbone cycles cannot be aborted); rsp_valid pulse still issued; requester ignores it.
- Other requesters' req_valid changes during BUS/RESP have no effect until next IDLE.
- Reset values: cyc, stb, rsp_valid, rsp_err, busy = 0; cfu_ram_adr, rsp_data = 0; state IDLE; ptr 0. Reset asserted mid-BUS drops cyc/stb immediately (async).

## Timing
- Posedge clk only.
- Request seen high at edge T0 (IDLE) -> cyc/stb high from T1.
- ack sampled at edge Tk -> cyc/stb low and rsp_valid high after Tk, for one cycle.
- Zero-wait slave (ack in first BUS cycle): req at T0 -> rsp_valid in cycle after T1 = 2-cycle latency.
- Minimum 3 cycles between consecutive grants (IDLE, BUS, RESP); cyc is low for at least 2 cycles between bus cycles.
- rsp_data/rsp_err hold their last values until the next completion.

## Configuration
- CFU_RAM_ARB_TIMEOUT_EN defined: an 8..16-bit counter clears on BUS entry and increments each BUS cycle. If TIMEOUT_CYCLES is reached with no ack/err, cyc/stb drop, rsp_err=1, rsp_data=0, go RESP. ack/err on the same cycle as the timeout take precedence.
- Undefined: no counter; BUS waits indefinitely.

## Test plan
- Single request: req_valid=2'b01, adr0=30'h100, slave acks 1 cycle after stb with 32'hDEADBEEF -> cyc/stb 1 cycle, adr=30'h100, rsp_valid=2'b01 once, rsp_data=32'hDEADBEEF, rsp_err=0, total latency 2 cycles.
- Contention: req_valid=2'b11 held, adr0=30'h10, adr1=30'h20, zero-wait ack -> grants alternate 0,1,0,1; adr sequence 10,20,10,20; one rsp_valid pulse per grant.
- Error: slave asserts ack and err together on 3rd BUS cycle -> rsp_err=1, rsp_data unchanged from previous value, ptr advances.
- Requester drops req_valid mid-BUS with 5-wait-state slave -> cyc held 6 cycles, rsp_valid[0] still pulses, next grant goes to requester 1.
- Reset (reset=0) asserted during BUS -> cyc/stb/rsp_valid 0 immediately. After release, request from requester 1 alone is granted first cycle.
- With CFU_RAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 BUS cycles, rsp_err=1, rsp_data=0. Without the macro, cyc stays high for 100+ cycles.
